cpu_mult_seq: RTL and testbench
===============================

Name: cpu_mult_seq

Overview:
Multi-cycle 32x32 multiply sequencer for the Nios-style CPU datapath.
- Time-shares one pipelined 16x16 unsigned multiplier across four partial products: aL*bL, aH*bL, aL*bH, aH*bH.
- Accumulates the partial products into a 64-bit result and applies signed correction.
- Returns either the low or the high 32-bit word over a valid/ready handshake.
- Replaces two parallel multiplier cells with one shared hard multiplier.

Parameters:
MUL_PIPE, 1, register stages inside the 16x16 multiplier (legal: 1 or 2); product of an issue appears MUL_PIPE cycles later.

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  request present
in_ready  out  1  sequencer can accept (high only in IDLE)
in_op  in  2  00 MUL (low 32), 01 MULXUU, 10 MULXSU (a signed, b unsigned), 11 MULXSS
in_src1  in  32  operand a
in_src2  in  32  operand b
out_valid  out  1  result present
out_ready  in  1  consumer takes result
out_result  out  32  low or high word of product
busy  out  1  state != IDLE

Behaviour:
- Reset: one clock, reset is synchronous and active-low (clk, reset_n). With reset_n low at a rising edge:
  - state goes to IDLE; accumulator, issue counter and tag pipe are cleared;
  - out_valid=0, out_result=0, busy=0, in_ready=1 on the following cycle.
- Reset mid-operation aborts the operation silently; no partial result is ever presented.
- Accept: in_valid & in_ready at edge T latches op, a and b. Inputs are ignored whenever in_ready=0.
- States:
  - IDLE -> ISSUE on accept.
  - ISSUE: one partial product issued per cycle, counter k=0..N-1. N=3 for MUL (aH*bH skipped), N=4 for MULX*.
  - ISSUE -> DRAIN after the last issue. DRAIN lasts MUL_PIPE cycles.
  - DRAIN -> FIX for MULX*, DRAIN -> DONE for MUL.
  - FIX lasts one cycle, then -> DONE.
  - DONE holds until out_ready, then -> IDLE.
- Accumulation:
  - Each issue carries a shift tag through a MUL_PIPE-deep pipe: k0 shift 0, k1 shift 16, k2 shift 16, k3 shift 32.
  - On product arrival, acc += product << shift, in 64 bits, modulo 2^64.
  - Accumulation overlaps ISSUE; the last add happens in the final DRAIN cycle.
- FIX, on hi = acc[63:32], modulo 2^32:
  - MULXSU: hi -= (a[31] ? b : 0)
  - MULXSS: hi -= (a[31] ? b : 0) + (b[31] ? a : 0)
  - MULXUU: no change
- Output:
  - out_result is registered when entering DONE: acc[31:0] for MUL, corrected hi for MULX*.
  - out_valid=1 only in DONE. out_valid and out_result stay stable until out_ready is sampled high.
  - in_ready returns the cycle after the out handshake (no overlap).
- Latency for MUL_PIPE=1, accept at T: MUL gives out_valid at T+5; MULX* gives out_valid at T+7. In general MUL = T+N+MUL_PIPE+1; MULX* adds one cycle.
- Simultaneous events: out_ready high in the same cycle DONE is entered completes the handshake at that edge. in_valid in DONE is not accepted.

Optional Feature:
CPU_MULT_SEQ_ZERO_SKIP_EN
- Defined: at accept, if in_src1==0 or in_src2==0, go IDLE -> DONE directly with out_result=0. out_valid is high at T+1, and the multiplier is not issued.
- Undefined: zero operands take the full sequence; the result is identical, latency unchanged.

Decomposition:
- Package cpu_mult_seq_pkg:
  - op encodings (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS);
  - state enum (IDLE, ISSUE, DRAIN, FIX, DONE);
  - widths DATA_W=32, HALF_W=16, ACC_W=64;
  - shift-tag encoding.
- Sub-module cpu_mult_seq_mul16: 16x16 unsigned multiplier with MUL_PIPE output registers, synchronous clear on reset_n low. Maps to the hard DSP block.

Test Plan:
- MUL 0x00010003 * 0x00020005, out_ready=1 -> out_result 0x000B000F, out_valid at T+5 for one cycle.
- MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE at T+7.
- MULXSS 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000; MULXSS 0x80000000 * 0x80000000 -> 0x40000000.
- MULXSU 0xFFFFFFFE * 0x00000003 -> 0xFFFFFFFF.
- Backpressure: MUL 7*6 with out_ready low 5 cycles and in_valid toggling -> out_result 0x0000002A stable, in_ready=0 throughout, no extra accept. Second op accepted only after the handshake.
- Reset_n low for one cycle at T+3 of a MULXSS -> next cycle IDLE, out_valid=0. A following MULXUU 0x00010000 * 0x00010000 -> 0x00000001 at T'+7.
- With CPU_MULT_SEQ_ZERO_SKIP_EN: MULXSS 0 * 0x1234 -> out_result 0 at T+1. Without the macro: out_result 0 at T+7.

Source files
------------

// File: rtl/cpu_mult_seq_pkg.sv
// Shared types and helpers for the cpu_mult_seq 32x32 multiply sequencer.
// Covers the op encodings, FSM states, partial-product shift tags and widths.
package cpu_mult_seq_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;
    localparam int ACC_W  = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIX   = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SH_0  = 2'd0,
        SH_16 = 2'd1,
        SH_32 = 2'd2
    } shift_t;

    typedef struct packed {
        logic   valid;
        shift_t shift;
    } tag_t;

    // Index of the final partial product: MUL never needs aH*bH.
    function automatic logic [1:0] last_issue(input op_t op);
        return (op == OP_MUL) ? 2'd2 : 2'd3;
    endfunction

    function automatic shift_t issue_shift_of(input logic [1:0] k);
        case (k)
            2'd0:    return SH_0;
            2'd3:    return SH_32;
            default: return SH_16;
        endcase
    endfunction

    function automatic logic [ACC_W-1:0] shift_product(input logic [2*HALF_W-1:0] p,
                                                       input shift_t s);
        case (s)
            SH_0:    return {32'h0, p};
            SH_16:   return {16'h0, p, 16'h0};
            SH_32:   return {p, 32'h0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_mult_seq_mul16.sv
// 16x16 unsigned multiplier with MUL_PIPE output register stages (hard DSP block).
// The product of operands presented before an edge is visible MUL_PIPE edges later.
module cpu_mult_seq_mul16
    import cpu_mult_seq_pkg::*;
#(
    parameter int MUL_PIPE = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [HALF_W-1:0]     a,
    input  logic [HALF_W-1:0]     b,
    output logic [2*HALF_W-1:0]   p
);

    logic [2*HALF_W-1:0] pipe [MUL_PIPE];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < MUL_PIPE; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= 32'(a) * 32'(b);
            for (int i = 1; i < MUL_PIPE; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign p = pipe[MUL_PIPE-1];

endmodule

// File: rtl/cpu_mult_seq.sv
// Multi-cycle 32x32 multiply sequencer sharing one pipelined 16x16 multiplier.
// Optional CPU_MULT_SEQ_ZERO_SKIP_EN: a zero operand finishes straight from IDLE.
module cpu_mult_seq
    import cpu_mult_seq_pkg::*;
#(
    parameter int MUL_PIPE = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    // Handshakes: a transfer happens at a rising edge where valid and ready are
    // both high. in_ready is high only in IDLE; out_valid is high only in DONE
    // and out_result is held until the consumer's out_ready completes it.

    state_t              state;
    op_t                 op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [1:0]          cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    tag_t                tag_pipe [MUL_PIPE];
    tag_t                tag_out;
    logic                issuing;
    logic                accept;
    shift_t              issue_shift;
    logic [HALF_W-1:0]   mul_a;
    logic [HALF_W-1:0]   mul_b;
    logic [2*HALF_W-1:0] mul_p;
    logic [DATA_W-1:0]   corr_a;
    logic [DATA_W-1:0]   corr_b;
    logic [DATA_W-1:0]   hi_fix;

    assign issuing     = (state == ISSUE);
    assign accept      = in_valid && in_ready;
    assign issue_shift = issue_shift_of(cnt);

    // k0 aL*bL, k1 aH*bL, k2 aL*bH, k3 aH*bH
    assign mul_a = cnt[0] ? a_q[DATA_W-1:HALF_W] : a_q[HALF_W-1:0];
    assign mul_b = cnt[1] ? b_q[DATA_W-1:HALF_W] : b_q[HALF_W-1:0];

    cpu_mult_seq_mul16 #(.MUL_PIPE(MUL_PIPE)) u_mul16 (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (mul_a),
        .b       (mul_b),
        .p       (mul_p)
    );

    assign tag_out  = tag_pipe[MUL_PIPE-1];
    assign acc_next = tag_out.valid ? acc + shift_product(mul_p, tag_out.shift) : acc;

    // Signed correction of the unsigned high word.
    assign corr_a = ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[DATA_W-1]) ? b_q : '0;
    assign corr_b = ((op_q == OP_MULXSS) && b_q[DATA_W-1]) ? a_q : '0;
    assign hi_fix = acc[ACC_W-1:DATA_W] - corr_a - corr_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc <= '0;
            for (int i = 0; i < MUL_PIPE; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: issuing, shift: issue_shift};
            for (int i = 1; i < MUL_PIPE; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            acc <= accept ? '0 : acc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_q       <= OP_MUL;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= op_t'(in_op);
                        a_q      <= in_src1;
                        b_q      <= in_src2;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
`ifdef CPU_MULT_SEQ_ZERO_SKIP_EN
                        if (in_src1 == '0 || in_src2 == '0) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= '0;
                        end else
`endif
                        begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (cnt == last_issue(op_q)) begin
                        state <= DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DRAIN: begin
                    // The last product lands on the final DRAIN edge, so use acc_next.
                    if (cnt == 2'(MUL_PIPE - 1)) begin
                        cnt <= '0;
                        if (op_q == OP_MUL) begin
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= acc_next[DATA_W-1:0];
                        end else begin
                            state <= FIX;
                        end
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                FIX: begin
                    state      <= DONE;
                    out_valid  <= 1'b1;
                    out_result <= hi_fix;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mult_seq.sv
// Self-checking bench for cpu_mult_seq: vector table, scoreboard queue and
// hand-written reset/backpressure sequences.
module tb_cpu_mult_seq;

    localparam int MUL_PIPE = 1;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int n_pass;
    int n_total;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stall;
        bit          toggle;
    } vec_t;

    vec_t vecs[10];

    cpu_mult_seq #(.MUL_PIPE(MUL_PIPE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: signed/unsigned extension to 64 bits, then a plain 64-bit multiply.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (op == 2'b10 || op == 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
`ifdef CPU_MULT_SEQ_ZERO_SKIP_EN
        if (a == 32'h0 || b == 32'h0) return 1;
`endif
        if (op == 2'b00) return 3 + MUL_PIPE + 1;
        return 4 + MUL_PIPE + 2;
    endfunction

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // driver + monitor for one operation; called at a negedge
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int stall,
                          input bit toggle);
        int          guard;
        int          lat;
        int          want_lat;
        bit          timeout;
        bit          ir_bad;
        bit          stable_bad;
        logic [31:0] got;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, " in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        in_op     = op;
        in_src1   = a;
        in_src2   = b;
        out_ready = (stall == 0);
        exp_q.push_back(exp);
        want_lat  = exp_latency(op, a, b);
        @(posedge clk);
        lat        = 0;
        timeout    = 1'b1;
        ir_bad     = 1'b0;
        stable_bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            lat++;
            if (toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                in_op    = 2'($urandom_range(0, 3));
                in_src1  = $urandom;
                in_src2  = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                timeout = 1'b0;
                break;
            end
            if (in_ready) ir_bad = 1'b1;
        end
        if (timeout) begin
            check({name, " out_valid_timeout"}, 0, 1);
            void'(exp_q.pop_front());
            in_valid = 1'b0;
            pulse_reset();
            return;
        end
        check({name, " latency"}, lat, want_lat);
        got = out_result;
        check({name, " result"}, got, exp_q.pop_front());
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!out_valid || out_result !== got) stable_bad = 1'b1;
            if (in_ready) ir_bad = 1'b1;
            if (toggle) begin
                in_valid = 1'($urandom_range(0, 1));
                in_src1  = $urandom;
            end
        end
        if (stall > 0) begin
            check({name, " held_stable"}, stable_bad, 0);
            out_ready = 1'b1;
            if (toggle) in_valid = 1'b1;
        end
        check({name, " in_ready_low_while_busy"}, ir_bad, 0);
        @(negedge clk);
        in_valid = 1'b0;
        check({name, " out_valid_after_hs"}, out_valid, 0);
        check({name, " in_ready_after_hs"}, in_ready, 1);
        check({name, " busy_after_hs"}, busy, 0);
    endtask

    initial begin
        bit          ov_seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        n_pass    = 0;
        n_total   = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_src1   = '0;
        in_src2   = '0;
        out_ready = 1'b0;

        vecs[0] = '{"mul_basic",    2'b00, 32'h00010003, 32'h00020005, 32'h000B000F, 0, 1'b0};
        vecs[1] = '{"mulxuu_ones",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1'b0};
        vecs[2] = '{"mulxss_ones",  2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 0, 1'b0};
        vecs[3] = '{"mulxss_min",   2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 0, 1'b0};
        vecs[4] = '{"mulxsu_neg",   2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 0, 1'b0};
        vecs[5] = '{"mul_backpress",2'b00, 32'h00000007, 32'h00000006, 32'h0000002A, 5, 1'b1};
        vecs[6] = '{"mul_after_bp", 2'b00, 32'h00000003, 32'h00000004, 32'h0000000C, 0, 1'b0};
        vecs[7] = '{"mulxss_zero",  2'b11, 32'h00000000, 32'h00001234, 32'h00000000, 0, 1'b0};
        vecs[8] = '{"mulxsu_min",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0};
        vecs[9] = '{"mul_ones_lo",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1, 1'b0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("reset out_valid", out_valid, 0);
        check("reset out_result", out_result, 0);
        check("reset busy", busy, 0);
        check("reset in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].stall, vecs[i].toggle);
        end

        // reset sampled low at T+3 of a MULXSS aborts it silently
        in_valid = 1'b1;
        in_op    = 2'b11;
        in_src1  = 32'hFFFFFFFF;
        in_src2  = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        check("abort out_result", out_result, 0);
        ov_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
        end
        check("abort no_partial_result", ov_seen, 0);
        run_op("mulxuu_after_abort", 2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 0, 1'b0);

        // random operands, expected values from the reference model
        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) ra = 32'h7FFFFFFF;
            if (i == 1) rb = 32'h0;
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb),
                   $urandom_range(0, 2), 1'b0);
        end

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
